// File: rtl/sha_host_pkg.sv
// Shared types and constants for the SHA host memory bridge.
// Holds the controller state encoding, digest geometry and byte-lane helpers.
package sha_host_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLaunch,
    StRun,
    StFetch,
    StOut
  } sha_state_e;

  localparam int unsigned DIGEST_WORDS = 8;
  localparam int unsigned BytesPerWord = 4;
  localparam logic [1:0]  LastLane     = 2'd3;

  // Big-endian packing: lane 0 is the first byte of the word and lands in [31:24].
  function automatic logic [31:0] insert_byte(logic [31:0] word, logic [1:0] lane,
                                              logic [7:0] data);
    logic [31:0] res;
    res = word;
    unique case (lane)
      2'd0: res[31:24] = data;
      2'd1: res[23:16] = data;
      2'd2: res[15:8]  = data;
      2'd3: res[7:0]   = data;
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sha_host_ram.sv
// Single-port word RAM with a registered (1-cycle) read, shared by the loader,
// the hash core and the digest fetcher. Contents are never cleared.
module sha_host_ram
  import sha_host_pkg::*;
#(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/sha_host_mem.sv
// Host-side bridge for a SHA core: packs a host byte stream into RAM, launches the core,
// serves its memory accesses, then streams the digest back out.
// Optional RUN watchdog is compiled in with SHA_HOST_TIMEOUT_EN.
module sha_host_mem
  import sha_host_pkg::*;
#(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned OUT_BASE       = 1016,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,

  output logic        core_start,
  output logic [31:0] core_message_addr,
  output logic [31:0] core_size,
  output logic [31:0] core_output_addr,

  input  logic        core_done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,

  output logic        busy,
  output logic        overflow,
  output logic        timeout
);

  localparam int unsigned AddrW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SizeMax        = 32'(OUT_BASE * BytesPerWord);
  localparam logic [15:0] LastDigestAddr = 16'(OUT_BASE + DIGEST_WORDS - 1);
  localparam logic [2:0]  LastWord       = 3'(DIGEST_WORDS - 1);

  sha_state_e  state_q;
  logic [31:0] byte_cnt_q;
  logic [31:0] size_q;
  logic [31:0] word_q;
  logic [2:0]  k_q;
  logic        core_start_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic        overflow_q;
  logic        seen_last_q;
  logic        rd_ok_q;

  logic             accept;
  logic             full;
  logic [31:0]      ld_word;
  logic             ld_we;
  logic [AddrW-1:0] ld_addr;
  logic             core_in_range;
  logic             core_we;
  logic             digest_done;
  logic [AddrW-1:0] fetch_addr;

  logic             ram_we;
  logic [AddrW-1:0] ram_addr;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;

`ifdef SHA_HOST_TIMEOUT_EN
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] run_cnt_q;
  logic        timeout_q;
  assign timeout = timeout_q;
`else
  // Parameter stays in the interface so both builds share one instantiation.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign in_ready = (state_q == StIdle) || (state_q == StLoad);
  assign busy     = (state_q != StIdle);
  assign accept   = in_valid && in_ready;

  // Once the message area is full, further bytes are swallowed and the size saturates.
  assign full    = (byte_cnt_q >= SizeMax);
  assign ld_word = insert_byte(word_q, byte_cnt_q[1:0], in_data);
  assign ld_we   = accept && !full && ((byte_cnt_q[1:0] == LastLane) || in_last);
  assign ld_addr = AddrW'(byte_cnt_q >> 2);

  assign core_in_range = (32'(mem_addr) < DEPTH);
  assign core_we       = (state_q == StRun) && mem_we && core_in_range;
  // A done left high from an earlier run only counts once the last digest word is written.
  assign digest_done   = core_done && (seen_last_q || (core_we && (mem_addr == LastDigestAddr)));
  assign fetch_addr    = AddrW'(OUT_BASE + 32'(k_q));

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state_q)
      StIdle, StLoad: begin
        ram_we    = ld_we;
        ram_addr  = ld_addr;
        ram_wdata = ld_word;
      end
      StRun: begin
        ram_we    = core_we;
        ram_addr  = AddrW'(mem_addr);
        ram_wdata = mem_write_data;
      end
      StFetch, StOut: begin
        ram_addr = fetch_addr;
      end
      default: ;
    endcase
  end

  sha_host_ram #(
    .Depth (DEPTH),
    .AddrW (AddrW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      size_q       <= '0;
      word_q       <= '0;
      k_q          <= '0;
      core_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      overflow_q   <= 1'b0;
      seen_last_q  <= 1'b0;
      rd_ok_q      <= 1'b0;
`ifdef SHA_HOST_TIMEOUT_EN
      run_cnt_q    <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      rd_ok_q <= (state_q == StRun) && core_in_range;
      unique case (state_q)
        StIdle, StLoad: begin
          if (accept) begin
            if (full) begin
              overflow_q <= 1'b1;
            end
            if (in_last) begin
              size_q       <= full ? byte_cnt_q : byte_cnt_q + 32'd1;
              byte_cnt_q   <= '0;
              word_q       <= '0;
              seen_last_q  <= 1'b0;
              core_start_q <= 1'b1;
              state_q      <= StLaunch;
            end else begin
              if (!full) begin
                byte_cnt_q <= byte_cnt_q + 32'd1;
                word_q     <= ld_we ? '0 : ld_word;
              end
              state_q <= StLoad;
            end
          end
        end
        StLaunch: begin
          core_start_q <= 1'b0;
          state_q      <= StRun;
`ifdef SHA_HOST_TIMEOUT_EN
          run_cnt_q    <= '0;
`endif
        end
        StRun: begin
          if (core_we && (mem_addr == LastDigestAddr)) begin
            seen_last_q <= 1'b1;
          end
          if (digest_done) begin
            k_q     <= '0;
            state_q <= StFetch;
          end
`ifdef SHA_HOST_TIMEOUT_EN
          else if (run_cnt_q >= TimeoutLast) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            run_cnt_q <= run_cnt_q + 32'd1;
          end
`endif
        end
        StFetch: begin
          out_valid_q <= 1'b1;
          out_last_q  <= (k_q == LastWord);
          state_q     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              k_q     <= '0;
              state_q <= StIdle;
            end else begin
              k_q     <= k_q + 3'd1;
              state_q <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_start        = core_start_q;
  assign core_message_addr = '0;
  assign core_output_addr  = 32'(OUT_BASE);
  assign core_size         = size_q;
  assign out_valid         = out_valid_q;
  assign out_last          = out_last_q;
  // RAM data is held in OUT because the fetch address stays on word k.
  assign out_data          = ram_rdata;
  assign mem_read_data     = rd_ok_q ? ram_rdata : '0;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_sha_host_mem.sv
// Directed bench for sha_host_mem: load/pack, core memory port, digest stream,
// stale done, overflow, reset abort and (when compiled in) the watchdog.
module tb_sha_host_mem;

  localparam int unsigned OutBase = 1016;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid, out_last;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        core_start;
  logic [31:0] core_message_addr, core_size, core_output_addr;
  logic        core_done = 1'b0, mem_we = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  logic [31:0] mem_write_data = 32'h0;
  logic [31:0] mem_read_data;
  logic        busy, overflow, timeout;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_w [8];

  sha_host_mem #(
    .DEPTH          (1024),
    .OUT_BASE       (OutBase),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_last           (in_last),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_last          (out_last),
    .core_start        (core_start),
    .core_message_addr (core_message_addr),
    .core_size         (core_size),
    .core_output_addr  (core_output_addr),
    .core_done         (core_done),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_write_data    (mem_write_data),
    .mem_read_data     (mem_read_data),
    .busy              (busy),
    .overflow          (overflow),
    .timeout           (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic core_write(input int unsigned addr, input logic [31:0] data);
    mem_we         = 1'b1;
    mem_addr       = 16'(addr);
    mem_write_data = data;
    step();
    mem_we = 1'b0;
  endtask

  task automatic core_read(input string tag, input int unsigned addr, input logic [31:0] exp);
    mem_addr = 16'(addr);
    step();
    check(tag, mem_read_data, exp);
  endtask

  // Drains the 8-word digest against exp_w, optionally with random backpressure.
  task automatic drain(input bit rnd);
    int hs;
    logic stall;
    logic [31:0] held;
    bit rdy;
    hs = 0;
    stall = 1'b0;
    held = '0;
    for (int c = 0; c < 400 && hs < 8; c++) begin
      if (stall) begin
        check("out_valid_hold", 32'(out_valid), 32'd1);
        check("out_data_hold", out_data, held);
      end
      rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      out_ready = rdy;
      if (out_valid) check("in_ready_in_out", 32'(in_ready), 32'd0);
      if (out_valid && rdy) begin
        check("digest_word", out_data, exp_w[hs]);
        check("out_last", 32'(out_last), 32'(hs == 7));
        hs++;
      end
      stall = out_valid && !rdy;
      held  = out_data;
      step();
    end
    out_ready = 1'b0;
    check("handshakes", 32'(hs), 32'd8);
  endtask

  initial begin
    bit saw_valid;
    int n;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_core_size", core_size, 32'd0);

    // Message "abc"
    send_byte(8'h61, 1'b0);
    check("load_busy", 32'(busy), 32'd1);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    check("launch_start", 32'(core_start), 32'd1);
    check("launch_size", core_size, 32'd3);
    check("launch_msg_addr", core_message_addr, 32'd0);
    check("launch_out_addr", core_output_addr, OutBase);
    check("launch_in_ready", 32'(in_ready), 32'd0);
    step();
    check("start_one_cycle", 32'(core_start), 32'd0);
    check("run_size_stable", core_size, 32'd3);

    core_write(5, 32'h1234_5678);
    core_write(976, 32'hcafe_f00d);
    core_write(2000, 32'hdead_beef);
    core_read("ram0_abc", 0, 32'h6162_6300);
    core_read("core_rd_5", 5, 32'h1234_5678);
    core_read("core_rd_oob", 2000, 32'h0);
    core_read("oob_wr_ignored", 976, 32'hcafe_f00d);

    exp_w = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
              32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    for (int i = 0; i < 8; i++) core_write(OutBase + i, exp_w[i]);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("valid_not_1_cycle", 32'(out_valid), 32'd0);
    step();
    check("valid_2_cycles", 32'(out_valid), 32'd1);

    in_valid = 1'b1;
    in_data  = 8'haa;
    drain(1'b1);
    in_valid = 1'b0;
    check("idle_after_digest", 32'(busy), 32'd0);
    out_ready = 1'b1;
    step();
    check("no_byte_taken_in_out", 32'(busy), 32'd0);
    check("no_9th_word", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Core write while idle must not reach RAM
    core_write(5, 32'h0);
    core_done = 1'b1;
    send_byte(8'h68, 1'b0);
    send_byte(8'h65, 1'b0);
    send_byte(8'h6c, 1'b0);
    send_byte(8'h6c, 1'b0);
    send_byte(8'h6f, 1'b1);
    check("hello_size", core_size, 32'd5);
    step();
    core_read("hello_w1", 1, 32'h6f00_0000);
    core_read("hello_w0", 0, 32'h6865_6c6c);
    core_read("idle_wr_ignored", 5, 32'h1234_5678);
    for (int i = 0; i < 8; i++) exp_w[i] = 32'h0101_0101 * 32'(i + 1);
    for (int i = 0; i < 7; i++) core_write(OutBase + i, exp_w[i]);
    check("stale_done_held", 32'(busy), 32'd1);
    check("stale_done_no_valid", 32'(out_valid), 32'd0);
    core_write(OutBase + 7, exp_w[7]);
    check("fetch_no_valid_yet", 32'(out_valid), 32'd0);
    step();
    core_done = 1'b0;
    check("done_after_last_wr", 32'(out_valid), 32'd1);
    drain(1'b0);

    // Reset in the middle of RUN
    send_byte(8'h55, 1'b1);
    step();
    check("midrun_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_core_start", 32'(core_start), 32'd0);
    check("abort_size", core_size, 32'd0);

    // Overflow: OUT_BASE*4 + 3 bytes
    for (int i = 0; i < OutBase * 4 + 3; i++) begin
      send_byte(8'(i), i == OutBase * 4 + 2);
      if (i == OutBase * 4 - 1) check("ovf_at_limit", 32'(overflow), 32'd0);
      if (i == OutBase * 4) check("ovf_past_limit", 32'(overflow), 32'd1);
    end
    check("ovf_size", core_size, 32'd4064);
    check("ovf_start", 32'(core_start), 32'd1);
    step();
    core_read("ovf_last_word", OutBase - 1, 32'hdcdd_dedf);
    core_read("ovf_no_spill", OutBase, 32'h0101_0101);

    saw_valid = 1'b0;
    n = 0;
`ifdef SHA_HOST_TIMEOUT_EN
    while (busy && n < 100) begin
      if (out_valid) saw_valid = 1'b1;
      step();
      n++;
    end
    check("timeout_exit", 32'(busy), 32'd0);
    check("timeout_flag", 32'(timeout), 32'd1);
    check("timeout_no_digest", 32'(saw_valid), 32'd0);
`else
    while (n < 80) begin
      if (out_valid) saw_valid = 1'b1;
      step();
      n++;
    end
    check("run_waits", 32'(busy), 32'd1);
    check("timeout_tied", 32'(timeout), 32'd0);
    check("run_no_digest", 32'(saw_valid), 32'd0);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("final_overflow_clr", 32'(overflow), 32'd0);
    check("final_timeout_clr", 32'(timeout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha_host_mem.md
SHA_HOST_MEM -- requirements
Module: sha_host_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, words of message/digest RAM.
REQ-002 SHALL have parameter OUT_BASE, default 1016, word address where the core writes the digest; message words occupy 0..OUT_BASE-1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536, watchdog limit (used only with SHA_HOST_TIMEOUT_EN).
REQ-004 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-005 SHALL have ports: in_valid  in  1, in_ready  out  1, in_data  in  8, in_last  in  1; host byte stream, one byte per beat.
REQ-006 SHALL have ports: out_valid  out  1, out_ready  in  1, out_data  out  32, out_last  out  1; digest word stream.
REQ-007 SHALL have ports: core_start  out  1, core_message_addr  out  32, core_size  out  32, core_output_addr  out  32; launch signals to the hash core.
REQ-008 SHALL have ports: core_done  in  1, mem_we  in  1, mem_addr  in  16, mem_write_data  in  32, mem_read_data  out  32; memory responder for the core, on the same clk.
REQ-009 SHALL have ports: busy  out  1, overflow  out  1 (sticky), timeout  out  1 (sticky).

Function
REQ-010 SHALL implement the states IDLE, LOAD, LAUNCH, RUN, FETCH, OUT.
REQ-011 IDLE/LOAD: in_ready=1; bytes pack big-endian (first byte -> [31:24]); a word is written at byte_cnt/4 when 4 bytes are collected or on in_last, with unused lanes zero.
REQ-012 IDLE -> LOAD on the first accepted byte; LOAD/IDLE -> LAUNCH on an accepted byte with in_last=1.
REQ-013 Bytes beyond OUT_BASE*4 SHALL be accepted and discarded, the size SHALL saturate at OUT_BASE*4, and overflow SHALL set.
REQ-014 LAUNCH: core_start=1 for exactly one cycle; core_message_addr=0, core_output_addr=OUT_BASE, and core_size=byte count, all held stable from LAUNCH until IDLE; then go to RUN.
REQ-015 In RUN, a read SHALL return RAM[mem_addr] on mem_read_data one cycle after the address is sampled; mem_we=1 writes mem_write_data the same edge.
REQ-016 A core access with mem_addr>=DEPTH SHALL read 0 and its write SHALL be ignored; core writes outside RUN SHALL be ignored.
REQ-017 RUN -> FETCH when core_done=1 and a core write to OUT_BASE+7 has been seen since LAUNCH; a stale-high core_done alone SHALL NOT exit RUN.
REQ-018 FETCH reads RAM[OUT_BASE+k] and goes to OUT one cycle later; out_valid SHALL assert 2 cycles after the qualifying core_done edge.
REQ-019 OUT: out_data and out_valid SHALL be held until out_ready; on the handshake k increments and the block returns to FETCH; out_last=1 only for k=7; the last handshake goes to IDLE.
REQ-020 busy=1 in every state except IDLE; in_ready=0 in LAUNCH, RUN, FETCH and OUT.
REQ-021 A simultaneous in_valid during OUT SHALL not be accepted; no byte is lost, because in_ready=0.

Reset
REQ-022 On reset: state=IDLE; core_start, out_valid, out_last, busy, overflow and timeout =0; counters =0; in_ready=1 the cycle after reset deasserts; RAM contents are not cleared.
REQ-023 Reset mid-RUN or mid-OUT SHALL abort the operation; the next message starts clean.

Configuration
REQ-024 With SHA_HOST_TIMEOUT_EN defined, a RUN cycle counter SHALL force RUN -> IDLE after TIMEOUT_CYCLES cycles, set timeout, and emit no digest.
REQ-025 Without SHA_HOST_TIMEOUT_EN, the counter and its logic SHALL be absent, RUN waits indefinitely, and timeout is tied 0.

Structure
REQ-026 Package sha_host_pkg SHALL hold the state enum, DIGEST_WORDS=8, and the byte-lane constants.
REQ-027 Sub-module sha_host_ram SHALL be the single-port, 1-cycle-read RAM, muxed between loader, core and fetch by state.

Verification
REQ-028 Load bytes 61 62 63 with last -> RAM[0]=61626300, core_size=3, core_start high for 1 cycle.
REQ-029 Core model writes ba7816bf..f20015ad to OUT_BASE..+7 then raises done -> out stream emits the 8 words in order, out_last on the 8th, out_valid 2 cycles after done.
REQ-030 Random out_ready backpressure -> out_data stable while valid&&!ready; exactly 8 handshakes.
REQ-031 Core read of address 5 then 2000 -> data RAM[5], then 0, each one cycle later.
REQ-032 Stream OUT_BASE*4+3 bytes -> overflow=1, core_size=4064.
REQ-033 Done held high from the previous run -> RUN is not exited until the new OUT_BASE+7 write; with SHA_HOST_TIMEOUT_EN and no done -> timeout=1 and return to IDLE; reset mid-RUN -> outputs at reset values the next cycle.
